img2col_tensor_addr_gen: RTL and testbench

- Consumer of the parameter set and `enable` published by the parameter-preparation stage.
- On the rising edge of `enable`, latches the convolution geometry and streams img2col tensor read addresses, one per accepted beat, over a valid/ready interface.
- Address order is output window (row-major) → channel → kernel row → kernel column.
- Tensor memory is channel-planar: addr = c·T² + (oy·S + ky)·T + (ox·S + kx).

---
 rtl/img2col_tensor_addr_gen.sv | 244 ++++++++++++++++++++++++
 tb/tb_img2col_tensor_addr_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/img2col_tensor_addr_gen.sv
// img2col address generator: streams channel-planar tensor read addresses for
// every K*K*C patch of every output window, one per accepted valid/ready beat.
module img2col_tensor_addr_gen #(
  parameter int TENSOR_SIZE   = 8,
  parameter int KERNEL_SIZE   = 4,
  parameter int CHANNELS_SIZE = 8,
  parameter int STRIDE_SIZE   = 4,
  parameter int ADDR_SIZE     = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [TENSOR_SIZE-1:0]             tensor_size,
  input  logic [KERNEL_SIZE-1:0]             kernel_size,
  input  logic [CHANNELS_SIZE-1:0]           channels,
  input  logic [STRIDE_SIZE-1:0]             stride,
  input  logic [TENSOR_SIZE+STRIDE_SIZE-1:0] t_addr_tms,
  input  logic [TENSOR_SIZE-1:0]             t_addr_ofs,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [ADDR_SIZE-1:0]               o_addr,
  output logic                               o_patch_last,
  output logic                               o_last,
  output logic                               o_busy,
  output logic                               o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [KERNEL_SIZE-1:0]   K_ONE = KERNEL_SIZE'(1'b1);
  localparam logic [CHANNELS_SIZE-1:0] C_ONE = CHANNELS_SIZE'(1'b1);
  localparam logic [TENSOR_SIZE-1:0]   T_ONE = TENSOR_SIZE'(1'b1);

  state_t state_q, state_d;
  logic   enable_q, enable_d;
  logic   armed_q, armed_d;

  logic [TENSOR_SIZE-1:0]             tsz_q, tsz_d;
  logic [KERNEL_SIZE-1:0]             ksz_q, ksz_d;
  logic [CHANNELS_SIZE-1:0]           chn_q, chn_d;
  logic [STRIDE_SIZE-1:0]             str_q, str_d;
  logic [TENSOR_SIZE+STRIDE_SIZE-1:0] tms_q, tms_d;
  logic [TENSOR_SIZE-1:0]             ofs_q, ofs_d;
  logic [ADDR_SIZE-1:0]               plane_q, plane_d;

  logic [KERNEL_SIZE-1:0]   kx_q, kx_d, ky_q, ky_d;
  logic [CHANNELS_SIZE-1:0] c_q, c_d;
  logic [TENSOR_SIZE-1:0]   ox_q, ox_d, oy_q, oy_d;
  logic [ADDR_SIZE-1:0]     ky_base_q, ky_base_d, ch_base_q, ch_base_d;
  logic [ADDR_SIZE-1:0]     win_base_q, win_base_d, row_base_q, row_base_d;

  logic [2*TENSOR_SIZE-1:0] plane_full_s;
  logic                     start_s, abort_s, fire_s, empty_s;
  logic                     kx_last_s, ky_last_s, c_last_s, ox_last_s, oy_last_s;
  logic                     patch_last_s, run_last_s;
  logic [ADDR_SIZE-1:0]     addr_s;

  // armed_q blocks a start from an enable that was already high when reset released
  assign start_s      = enable & ~enable_q & armed_q;
  assign abort_s      = ~enable & ((state_q == ST_LOAD) | (state_q == ST_RUN));
  assign fire_s       = (state_q == ST_RUN) & i_ready;
  assign empty_s      = (ksz_q == {KERNEL_SIZE{1'b0}}) | (chn_q == {CHANNELS_SIZE{1'b0}});
  assign plane_full_s = tsz_q * tsz_q;

  assign kx_last_s    = (kx_q == (ksz_q - K_ONE));
  assign ky_last_s    = (ky_q == (ksz_q - K_ONE));
  assign c_last_s     = (c_q == (chn_q - C_ONE));
  assign ox_last_s    = (ox_q == ofs_q);
  assign oy_last_s    = (oy_q == ofs_q);
  assign patch_last_s = kx_last_s & ky_last_s & c_last_s;
  assign run_last_s   = patch_last_s & ox_last_s & oy_last_s;
  assign addr_s       = row_base_q + win_base_q + ch_base_q + ky_base_q + ADDR_SIZE'(kx_q);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      enable_q   <= 1'b0;
      armed_q    <= 1'b0;
      tsz_q      <= {TENSOR_SIZE{1'b0}};
      ksz_q      <= {KERNEL_SIZE{1'b0}};
      chn_q      <= {CHANNELS_SIZE{1'b0}};
      str_q      <= {STRIDE_SIZE{1'b0}};
      tms_q      <= {(TENSOR_SIZE+STRIDE_SIZE){1'b0}};
      ofs_q      <= {TENSOR_SIZE{1'b0}};
      plane_q    <= {ADDR_SIZE{1'b0}};
      kx_q       <= {KERNEL_SIZE{1'b0}};
      ky_q       <= {KERNEL_SIZE{1'b0}};
      c_q        <= {CHANNELS_SIZE{1'b0}};
      ox_q       <= {TENSOR_SIZE{1'b0}};
      oy_q       <= {TENSOR_SIZE{1'b0}};
      ky_base_q  <= {ADDR_SIZE{1'b0}};
      ch_base_q  <= {ADDR_SIZE{1'b0}};
      win_base_q <= {ADDR_SIZE{1'b0}};
      row_base_q <= {ADDR_SIZE{1'b0}};
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      armed_q    <= armed_d;
      tsz_q      <= tsz_d;
      ksz_q      <= ksz_d;
      chn_q      <= chn_d;
      str_q      <= str_d;
      tms_q      <= tms_d;
      ofs_q      <= ofs_d;
      plane_q    <= plane_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      c_q        <= c_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      ky_base_q  <= ky_base_d;
      ch_base_q  <= ch_base_d;
      win_base_q <= win_base_d;
      row_base_q <= row_base_d;
    end
  end

  // Next-state logic; abort has priority over completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) state_d = ST_LOAD;
        else         state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (abort_s)      state_d = ST_IDLE;
        else if (empty_s) state_d = ST_DONE;
        else              state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort_s)                  state_d = ST_IDLE;
        else if (fire_s & run_last_s) state_d = ST_DONE;
        else                          state_d = ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow latch, plane multiply and nested counter advance
  always_comb begin
    enable_d   = enable;
    armed_d    = armed_q | ~enable;
    tsz_d      = tsz_q;
    ksz_d      = ksz_q;
    chn_d      = chn_q;
    str_d      = str_q;
    tms_d      = tms_q;
    ofs_d      = ofs_q;
    plane_d    = plane_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    c_d        = c_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    ky_base_d  = ky_base_q;
    ch_base_d  = ch_base_q;
    win_base_d = win_base_q;
    row_base_d = row_base_q;
    if ((state_q == ST_IDLE) && start_s) begin
      tsz_d = tensor_size;
      ksz_d = kernel_size;
      chn_d = channels;
      str_d = stride;
      tms_d = t_addr_tms;
      ofs_d = t_addr_ofs;
    end else begin
      tsz_d = tsz_q;
    end
    if (state_q == ST_LOAD) begin
      plane_d    = ADDR_SIZE'(plane_full_s);
      kx_d       = {KERNEL_SIZE{1'b0}};
      ky_d       = {KERNEL_SIZE{1'b0}};
      c_d        = {CHANNELS_SIZE{1'b0}};
      ox_d       = {TENSOR_SIZE{1'b0}};
      oy_d       = {TENSOR_SIZE{1'b0}};
      ky_base_d  = {ADDR_SIZE{1'b0}};
      ch_base_d  = {ADDR_SIZE{1'b0}};
      win_base_d = {ADDR_SIZE{1'b0}};
      row_base_d = {ADDR_SIZE{1'b0}};
    end else if (fire_s) begin
      if (kx_last_s) begin
        kx_d = {KERNEL_SIZE{1'b0}};
        if (ky_last_s) begin
          ky_d      = {KERNEL_SIZE{1'b0}};
          ky_base_d = {ADDR_SIZE{1'b0}};
          if (c_last_s) begin
            c_d       = {CHANNELS_SIZE{1'b0}};
            ch_base_d = {ADDR_SIZE{1'b0}};
            if (ox_last_s) begin
              ox_d       = {TENSOR_SIZE{1'b0}};
              win_base_d = {ADDR_SIZE{1'b0}};
              row_base_d = row_base_q + ADDR_SIZE'(tms_q);
              oy_d       = oy_q + T_ONE;
            end else begin
              ox_d       = ox_q + T_ONE;
              win_base_d = win_base_q + ADDR_SIZE'(str_q);
            end
          end else begin
            c_d       = c_q + C_ONE;
            ch_base_d = ch_base_q + plane_q;
          end
        end else begin
          ky_d      = ky_q + K_ONE;
          ky_base_d = ky_base_q + ADDR_SIZE'(tsz_q);
        end
      end else begin
        kx_d = kx_q + K_ONE;
      end
    end else begin
      kx_d = kx_q;
    end
  end

  // Outputs decoded from state; beat fields forced to zero outside RUN
  always_comb begin
    o_valid      = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_addr       = {ADDR_SIZE{1'b0}};
    o_patch_last = 1'b0;
    o_last       = 1'b0;
    case (state_q)
      ST_LOAD: o_busy = 1'b1;
      ST_RUN: begin
        o_valid      = 1'b1;
        o_busy       = 1'b1;
        o_addr       = addr_s;
        o_patch_last = patch_last_s;
        o_last       = run_last_s;
      end
      ST_DONE: o_done = 1'b1;
      default: o_done = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_img2col_tensor_addr_gen.sv
// Bench for img2col_tensor_addr_gen: table of geometries checked against a
// direct-formula scoreboard, plus abort, empty-run and reset sequences.
module tb_img2col_tensor_addr_gen;
  localparam int TW = 8, KW = 4, CW = 8, SW = 4, AW = 16;

  logic          clk = 1'b0;
  logic          rst, enable, i_ready;
  logic [TW-1:0] tensor_size, t_addr_ofs;
  logic [KW-1:0] kernel_size;
  logic [CW-1:0] channels;
  logic [SW-1:0] stride;
  logic [TW+SW-1:0] t_addr_tms;
  logic          o_valid, o_patch_last, o_last, o_busy, o_done;
  logic [AW-1:0] o_addr;

  img2col_tensor_addr_gen dut (
    .clk(clk), .rst(rst), .enable(enable),
    .tensor_size(tensor_size), .kernel_size(kernel_size), .channels(channels),
    .stride(stride), .t_addr_tms(t_addr_tms), .t_addr_ofs(t_addr_ofs),
    .o_valid(o_valid), .i_ready(i_ready), .o_addr(o_addr),
    .o_patch_last(o_patch_last), .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t, k, s, c, tms, ofs;
    int beats, last_addr;
    int idx_a, val_a, idx_b, val_b;
    bit bp;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          pl;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Direct formula: addr = c*T*T + (oy*S+ky)*T + ox*S + kx
  task automatic build_model(input vec_t v);
    beat_t b;
    exp_q.delete();
    for (int oy = 0; oy <= v.ofs; oy++)
      for (int ox = 0; ox <= v.ofs; ox++)
        for (int c = 0; c < v.c; c++)
          for (int ky = 0; ky < v.k; ky++)
            for (int kx = 0; kx < v.k; kx++) begin
              b.addr = AW'(c * v.t * v.t + (oy * v.s + ky) * v.t + ox * v.s + kx);
              b.pl   = (kx == v.k - 1) && (ky == v.k - 1) && (c == v.c - 1);
              b.last = b.pl && (ox == v.ofs) && (oy == v.ofs);
              exp_q.push_back(b);
            end
  endtask

  task automatic drive_geom(input vec_t v);
    tensor_size = TW'(v.t);
    kernel_size = KW'(v.k);
    channels    = CW'(v.c);
    stride      = SW'(v.s);
    t_addr_tms  = (TW+SW)'(v.tms);
    t_addr_ofs  = TW'(v.ofs);
  endtask

  task automatic run_case(input vec_t v, input int abort_after, input string tag);
    int    got[$];
    int    first_valid, done_cyc, last_cyc, acc;
    bit    prev_stall, dropped, quiet_bad;
    beat_t prev, b;
    build_model(v);
    drive_geom(v);
    enable = 1'b0;
    i_ready = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    first_valid = -1; done_cyc = -1; last_cyc = -1; acc = 0;
    prev_stall = 1'b0; dropped = 1'b0;
    prev = '{addr: '0, pl: 1'b0, last: 1'b0};
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      i_ready = v.bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (cyc == 1) check({tag, "_load_busy"}, {o_busy, o_valid}, 2);
      if (o_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall)
        check({tag, "_stall_hold"}, (o_valid && o_addr == prev.addr && o_patch_last == prev.pl
                                     && o_last == prev.last) ? 1 : 0, 1);
      if (o_valid && i_ready) begin
        acc++;
        got.push_back(int'(o_addr));
        if (o_last) last_cyc = cyc;
        if (exp_q.size() == 0) begin
          check({tag, "_extra_beat"}, int'(o_addr), -1);
        end else begin
          b = exp_q.pop_front();
          check({tag, "_addr"}, int'(o_addr), int'(b.addr));
          check({tag, "_flags"}, {o_patch_last, o_last}, {b.pl, b.last});
        end
      end
      prev_stall = o_valid && !i_ready;
      prev.addr = o_addr; prev.pl = o_patch_last; prev.last = o_last;
      if (o_done) begin
        done_cyc = cyc;
        check({tag, "_done_idle"}, {o_busy, o_valid}, 0);
        break;
      end
      if (abort_after > 0 && acc == abort_after) begin
        enable = 1'b0;
        dropped = 1'b1;
        break;
      end
    end
    if (abort_after > 0) begin
      check({tag, "_abort_reached"}, dropped, 1);
      @(negedge clk);
      check({tag, "_abort_valid"}, {o_valid, o_busy}, 0);
      quiet_bad = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (o_valid || o_done) quiet_bad = 1'b1;
      end
      check({tag, "_abort_quiet"}, quiet_bad, 0);
      check({tag, "_abort_beats"}, acc, abort_after);
      exp_q.delete();
    end else begin
      check({tag, "_done_seen"}, done_cyc > 0, 1);
      check({tag, "_beats"}, acc, v.beats);
      check({tag, "_leftover"}, exp_q.size(), 0);
      if (v.beats > 0) begin
        check({tag, "_first_valid"}, first_valid, 2);
        check({tag, "_done_after_last"}, done_cyc, last_cyc + 1);
        if (got.size() > 0) check({tag, "_last_addr"}, got[got.size()-1], v.last_addr);
        if (got.size() > v.idx_a) check({tag, "_idx_a"}, got[v.idx_a], v.val_a);
        if (got.size() > v.idx_b) check({tag, "_idx_b"}, got[v.idx_b], v.val_b);
      end else begin
        check({tag, "_empty_done"}, done_cyc, 2);
      end
    end
    enable = 1'b0;
    i_ready = 1'b0;
    @(negedge clk);
  endtask

  vec_t vecs[5];
  vec_t base_v;
  bit   rst_bad;

  initial begin
    vecs[0] = '{t:5, k:3, s:1, c:1, tms:5,  ofs:2, beats:81, last_addr:24,
                idx_a:8, val_a:12, idx_b:9,  val_b:1,  bp:1'b0};
    vecs[1] = '{t:5, k:3, s:2, c:1, tms:10, ofs:1, beats:36, last_addr:24,
                idx_a:9, val_a:2,  idx_b:27, val_b:12, bp:1'b0};
    vecs[2] = '{t:4, k:2, s:2, c:2, tms:8,  ofs:1, beats:32, last_addr:31,
                idx_a:4, val_a:16, idx_b:7,  val_b:21, bp:1'b0};
    vecs[3] = '{t:5, k:3, s:1, c:1, tms:5,  ofs:2, beats:81, last_addr:24,
                idx_a:8, val_a:12, idx_b:9,  val_b:1,  bp:1'b1};
    vecs[4] = '{t:5, k:3, s:1, c:0, tms:5,  ofs:2, beats:0,  last_addr:0,
                idx_a:0, val_a:0,  idx_b:0,  val_b:0,  bp:1'b0};
    base_v = vecs[0];

    rst = 1'b1; enable = 1'b0; i_ready = 1'b0;
    drive_geom(base_v);
    repeat (3) @(negedge clk);
    check("reset_outputs", {o_valid, o_busy, o_done, o_patch_last, o_last, o_addr}, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_case(vecs[i], 0, $sformatf("vec%0d", i));

    run_case(base_v, 20, "abort");
    run_case(base_v, 0, "restart");

    // Reset in the middle of a run with enable held high afterwards
    enable = 1'b0; i_ready = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (30) @(negedge clk);
    check("pre_reset_running", o_valid, 1);
    rst = 1'b1;
    #1;
    check("reset_mid_run", {o_valid, o_busy, o_done, o_patch_last, o_last, o_addr}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rst_bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid || o_busy || o_done) rst_bad = 1'b1;
    end
    check("no_beats_after_reset", rst_bad, 0);
    enable = 1'b0;
    @(negedge clk);

    run_case(vecs[2], 0, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
